// File: rtl/rotator_share_if.sv
// rotator_share_if: requester/result bundle between the two requesters, the result consumer and rotator_share_ctrl.
interface rotator_share_if;
    logic        req0, req1, dir0, dir1;
    logic [3:0]  amt0, amt1;
    logic [15:0] data0, data1;
    logic        gnt0, gnt1;
    logic [15:0] res;
    logic        res_vld, res_id, res_rdy, busy;

    modport master (
        output req0, req1, dir0, dir1, amt0, amt1, data0, data1, res_rdy,
        input  gnt0, gnt1, res, res_vld, res_id, busy
    );

    modport slave (
        input  req0, req1, dir0, dir1, amt0, amt1, data0, data1, res_rdy,
        output gnt0, gnt1, res, res_vld, res_id, busy
    );
endinterface

// File: rtl/rotator_share_ctrl.sv
// rotator_share_ctrl: round-robin sharing of one 16-bit rotate-right mux tree between two requesters,
// with a programmable settle time before capture and a back-pressurable result port.
module rotator_share_ctrl #(
    parameter int SETTLE_CYC = 2
) (
    input logic            clk,
    input logic            rst_n,
    rotator_share_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d, sel_q, sel_d;
    logic [15:0] opnd_q, opnd_d, res_q, res_d, rot;
    logic        owner_q, owner_d, last_q, last_d, vld_q, vld_d, id_q, id_d;
    logic        win, gnt0, gnt1;

    assign rot = 16'({opnd_q, opnd_q} >> sel_q);
    // a tie goes to whoever did not win last time; a lone request always wins
    assign win = (bus.req0 & bus.req1) ? ~last_q : bus.req1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        opnd_d  = opnd_q;
        owner_d = owner_q;
        last_d  = last_q;
        res_d   = res_q;
        vld_d   = vld_q;
        id_d    = id_q;
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        unique case (state_q)
            IDLE: if (bus.req0 | bus.req1) begin
                gnt0    = ~win;
                gnt1    = win;
                opnd_d  = win ? bus.data1 : bus.data0;
                // left by n is right by (16-n) mod 16
                sel_d   = win ? (bus.dir1 ? -bus.amt1 : bus.amt1) : (bus.dir0 ? -bus.amt0 : bus.amt0);
                owner_d = win;
                last_d  = win;
                cnt_d   = 4'(SETTLE_CYC - 1);
                state_d = SETTLE;
            end
            SETTLE: if (cnt_q != 4'd0) begin
                cnt_d = cnt_q - 4'd1;
            end else begin
                res_d   = rot;
                id_d    = owner_q;
                vld_d   = 1'b1;
                state_d = HOLD;
            end
            HOLD: if (bus.res_rdy) begin
                vld_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sel_q   <= '0;
            opnd_q  <= '0;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            res_q   <= '0;
            vld_q   <= 1'b0;
            id_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            opnd_q  <= opnd_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            res_q   <= res_d;
            vld_q   <= vld_d;
            id_q    <= id_d;
        end
    end

    assign bus.gnt0    = gnt0 & rst_n;
    assign bus.gnt1    = gnt1 & rst_n;
    assign bus.res     = res_q;
    assign bus.res_vld = vld_q;
    assign bus.res_id  = id_q;
    assign bus.busy    = state_q != IDLE;
endmodule

// File: tb/tb_rotator_share_ctrl.sv
// tb_rotator_share_ctrl: directed checks of rotator_share_ctrl; three instances (SETTLE_CYC 2, 1, 15) share one stimulus.
module tb_rotator_share_ctrl;
    logic clk = 1'b0, rst_n = 1'b0;
    logic req0 = 1'b0, req1 = 1'b0, dir0 = 1'b0, dir1 = 1'b0, rdy = 1'b1;
    logic [3:0] amt0 = '0, amt1 = '0;
    logic [15:0] data0 = '0, data1 = '0;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    rotator_share_if b2 ();
    rotator_share_if b1 ();
    rotator_share_if b15 ();

    assign {b2.req0, b2.req1, b2.dir0, b2.dir1, b2.amt0, b2.amt1, b2.data0, b2.data1, b2.res_rdy} = {req0, req1, dir0, dir1, amt0, amt1, data0, data1, rdy};
    assign {b1.req0, b1.req1, b1.dir0, b1.dir1, b1.amt0, b1.amt1, b1.data0, b1.data1, b1.res_rdy} = {req0, req1, dir0, dir1, amt0, amt1, data0, data1, rdy};
    assign {b15.req0, b15.req1, b15.dir0, b15.dir1, b15.amt0, b15.amt1, b15.data0, b15.data1, b15.res_rdy} = {req0, req1, dir0, dir1, amt0, amt1, data0, data1, rdy};

    rotator_share_ctrl #(.SETTLE_CYC(2))  u2  (.clk(clk), .rst_n(rst_n), .bus(b2));
    rotator_share_ctrl #(.SETTLE_CYC(1))  u1  (.clk(clk), .rst_n(rst_n), .bus(b1));
    rotator_share_ctrl #(.SETTLE_CYC(15)) u15 (.clk(clk), .rst_n(rst_n), .bus(b15));

    function automatic logic [15:0] model(input logic [15:0] d, input logic dir, input int a);
        int k = dir ? (16 - a) % 16 : a;
        logic [15:0] o;
        for (int i = 0; i < 16; i++) o[i] = d[(i + k) % 16];
        return o;
    endfunction

    task automatic do_reset;
        @(negedge clk);
        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; rdy = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // one request on the SETTLE_CYC=2 instance; returns grant lines seen in c0 and the first result
    task automatic run_op(input logic w, input logic d, input logic [3:0] a, input logic [15:0] x,
                          output logic g0, output logic g1, output logic [15:0] r, output logic id, output int lat);
        @(negedge clk);
        if (w) begin req1 = 1'b1; dir1 = d; amt1 = a; data1 = x; end
        else   begin req0 = 1'b1; dir0 = d; amt0 = a; data0 = x; end
        #1;
        g0 = b2.gnt0; g1 = b2.gnt1; lat = 0; r = 'x; id = 1'bx;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            req0 = 1'b0; req1 = 1'b0;
            #1;
            if (b2.res_vld) begin lat = c; r = b2.res; id = b2.res_id; break; end
        end
    endtask

    task automatic test_reset;
        @(negedge clk); #1;
        total += 4;
        if (b2.res !== 16'h0) begin bad++; $display("FAIL reset_res got=%h exp=0000", b2.res); end
        if ({b2.res_vld, b2.res_id} !== 2'b00) begin bad++; $display("FAIL reset_vld_id got=%b exp=00", {b2.res_vld, b2.res_id}); end
        if ({b2.gnt0, b2.gnt1} !== 2'b00) begin bad++; $display("FAIL reset_gnt got=%b exp=00", {b2.gnt0, b2.gnt1}); end
        if ({b2.busy, b1.busy, b15.busy} !== 3'b000) begin bad++; $display("FAIL reset_busy got=%b exp=000", {b2.busy, b1.busy, b15.busy}); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        logic g0, g1, id; logic [15:0] r; int lat;
        run_op(1'b0, 1'b0, 4'd1, 16'h8001, g0, g1, r, id, lat);
        total += 4;
        if ({g0, g1} !== 2'b10) begin bad++; $display("FAIL basic_gnt got=%b exp=10", {g0, g1}); end
        if (lat != 3) begin bad++; $display("FAIL basic_latency got=%0d exp=3", lat); end
        if (r !== 16'hC000) begin bad++; $display("FAIL basic_res got=%h exp=c000", r); end
        if (id !== 1'b0) begin bad++; $display("FAIL basic_id got=%b exp=0", id); end
        @(negedge clk); #1;
        total++;
        if ({b2.res_vld, b2.busy} !== 2'b00) begin bad++; $display("FAIL basic_c4_idle got vld,busy=%b exp=00", {b2.res_vld, b2.busy}); end
    endtask

    task automatic test_left_and_zero;
        logic g0, g1, id; logic [15:0] r; int lat;
        run_op(1'b1, 1'b1, 4'd4, 16'h1234, g0, g1, r, id, lat);
        total += 3;
        if ({g0, g1} !== 2'b01) begin bad++; $display("FAIL left_gnt got=%b exp=01", {g0, g1}); end
        if (r !== 16'h2341) begin bad++; $display("FAIL left_res got=%h exp=2341", r); end
        if (id !== 1'b1) begin bad++; $display("FAIL left_id got=%b exp=1", id); end
        run_op(1'b0, 1'b0, 4'd0, 16'h1234, g0, g1, r, id, lat);
        total++;
        if (r !== 16'h1234) begin bad++; $display("FAIL zero_right_res got=%h exp=1234", r); end
        run_op(1'b1, 1'b1, 4'd0, 16'h1234, g0, g1, r, id, lat);
        total++;
        if (r !== 16'h1234) begin bad++; $display("FAIL zero_left_res got=%h exp=1234", r); end
    endtask

    task automatic test_round_robin;
        int gq[$], gc[$], iq[$];
        logic [15:0] rq[$];
        logic [15:0] exp_r[2] = '{16'h8000, 16'h0002};
        do_reset;
        @(negedge clk);
        req0 = 1'b1; dir0 = 1'b0; amt0 = 4'd1; data0 = 16'h0001;
        req1 = 1'b1; dir1 = 1'b1; amt1 = 4'd1; data1 = 16'h0001;
        for (int c = 0; c < 40 && rq.size() < 4; c++) begin
            if (c) @(negedge clk);
            #1;
            total += 2;
            if (b2.gnt0 & b2.gnt1) begin bad++; $display("FAIL rr_both_gnt cycle=%0d got=11 exp=one-hot", c); end
            if ((b2.gnt0 | b2.gnt1) & b2.busy) begin bad++; $display("FAIL rr_gnt_busy cycle=%0d got=1 exp=0", c); end
            if (b2.gnt0 | b2.gnt1) begin gq.push_back(int'(b2.gnt1)); gc.push_back(c); end
            if (b2.res_vld) begin iq.push_back(int'(b2.res_id)); rq.push_back(b2.res); end
        end
        req0 = 1'b0; req1 = 1'b0;
        total++;
        if (gq.size() != 4 || rq.size() != 4) begin
            bad++; $display("FAIL rr_count got grants=%0d results=%0d exp=4,4", gq.size(), rq.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                total += 3;
                if (gq[i] != i % 2) begin bad++; $display("FAIL rr_order idx=%0d got=%0d exp=%0d", i, gq[i], i % 2); end
                if (iq[i] != i % 2) begin bad++; $display("FAIL rr_res_id idx=%0d got=%0d exp=%0d", i, iq[i], i % 2); end
                if (rq[i] !== exp_r[i % 2]) begin bad++; $display("FAIL rr_res idx=%0d got=%h exp=%h", i, rq[i], exp_r[i % 2]); end
            end
            for (int i = 0; i < 3; i++) begin
                total++;
                if (gc[i + 1] - gc[i] != 4) begin bad++; $display("FAIL rr_interval idx=%0d got=%0d exp=4", i, gc[i + 1] - gc[i]); end
            end
        end
    endtask

    task automatic test_back_pressure;
        logic seen = 1'b0;
        @(negedge clk);
        req0 = 1'b1; dir0 = 1'b0; amt0 = 4'd4; data0 = 16'h00F0; rdy = 1'b0;
        #1;
        total++;
        if ({b2.gnt0, b2.gnt1} !== 2'b10) begin bad++; $display("FAIL bp_gnt0 got=%b exp=10", {b2.gnt0, b2.gnt1}); end
        @(negedge clk);
        req0 = 1'b0; req1 = 1'b1; dir1 = 1'b0; amt1 = 4'd0; data1 = 16'h1234;
        #1;
        total++;
        if (b2.gnt1 !== 1'b0) begin bad++; $display("FAIL bp_gnt_in_settle got=%b exp=0", b2.gnt1); end
        for (int c = 0; c < 20 && !seen; c++) begin @(negedge clk); #1; seen = b2.res_vld; end
        total++;
        if (!seen) begin bad++; $display("FAIL bp_vld_timeout got=0 exp=1"); end
        for (int h = 0; h < 5; h++) begin
            if (h) begin @(negedge clk); #1; end
            total += 3;
            if (b2.res_vld !== 1'b1) begin bad++; $display("FAIL bp_hold_vld h=%0d got=%b exp=1", h, b2.res_vld); end
            if ({b2.res_id, b2.res} !== {1'b0, 16'h000F}) begin bad++; $display("FAIL bp_hold_res h=%0d got=%b/%h exp=0/000f", h, b2.res_id, b2.res); end
            if (b2.gnt1 !== 1'b0) begin bad++; $display("FAIL bp_hold_gnt h=%0d got=%b exp=0", h, b2.gnt1); end
        end
        @(negedge clk); rdy = 1'b1; #1;
        total++;
        if (b2.res_vld !== 1'b1) begin bad++; $display("FAIL bp_rdy_cycle_vld got=%b exp=1", b2.res_vld); end
        @(negedge clk); #1;
        total += 2;
        if (b2.res_vld !== 1'b0) begin bad++; $display("FAIL bp_vld_drop got=%b exp=0", b2.res_vld); end
        if ({b2.gnt0, b2.gnt1} !== 2'b01) begin bad++; $display("FAIL bp_pending_gnt got=%b exp=01", {b2.gnt0, b2.gnt1}); end
        @(negedge clk); req1 = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin @(negedge clk); #1; seen = b2.res_vld; end
        total++;
        if ({seen, b2.res_id, b2.res} !== {2'b11, 16'h1234}) begin bad++; $display("FAIL bp_pending_res got=%b/%b/%h exp=1/1/1234", seen, b2.res_id, b2.res); end
    endtask

    task automatic test_reset_mid;
        logic g0, g1, id, any_vld = 1'b0; logic [15:0] r; int lat;
        @(negedge clk);
        req0 = 1'b1; dir0 = 1'b0; amt0 = 4'd1; data0 = 16'h8001;
        @(negedge clk); req0 = 1'b0; #1;
        total++;
        if (b2.busy !== 1'b1) begin bad++; $display("FAIL mid_busy_before got=%b exp=1", b2.busy); end
        rst_n = 1'b0;
        #1;
        total += 3;
        if ({b2.busy, b2.res_vld, b2.gnt0, b2.gnt1} !== 4'b0000) begin bad++; $display("FAIL mid_ctrl got=%b exp=0000", {b2.busy, b2.res_vld, b2.gnt0, b2.gnt1}); end
        if (b2.res !== 16'h0) begin bad++; $display("FAIL mid_res got=%h exp=0000", b2.res); end
        if (b2.res_id !== 1'b0) begin bad++; $display("FAIL mid_res_id got=%b exp=0", b2.res_id); end
        @(negedge clk); rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin @(negedge clk); #1; any_vld |= b2.res_vld | b15.res_vld; end
        total++;
        if (any_vld !== 1'b0) begin bad++; $display("FAIL mid_no_result got=%b exp=0", any_vld); end
        run_op(1'b0, 1'b0, 4'd1, 16'h8001, g0, g1, r, id, lat);
        total++;
        if ({g0, g1, r, id, lat} !== {2'b10, 16'hC000, 1'b0, 32'd3}) begin bad++; $display("FAIL mid_after got=%b/%h/%b/%0d exp=10/c000/0/3", {g0, g1}, r, id, lat); end
    endtask

    task automatic test_settle_sweep;
        do_reset;
        for (int d = 0; d < 2; d++) begin
            for (int a = 0; a < 16; a++) begin
                int l1 = 0, l15 = 0;
                logic [15:0] r1 = 'x, r15 = 'x, e;
                e = model(16'hA5C3, d[0], a);
                @(negedge clk);
                req0 = 1'b1; dir0 = d[0]; amt0 = 4'(a); data0 = 16'hA5C3;
                #1;
                total++;
                if ({b1.gnt0, b15.gnt0} !== 2'b11) begin bad++; $display("FAIL sweep_gnt d=%0d a=%0d got=%b exp=11", d, a, {b1.gnt0, b15.gnt0}); end
                for (int c = 1; c <= 17; c++) begin
                    @(negedge clk); req0 = 1'b0; #1;
                    if (b1.res_vld && l1 == 0) begin l1 = c; r1 = b1.res; end
                    if (b15.res_vld && l15 == 0) begin l15 = c; r15 = b15.res; end
                end
                total += 4;
                if (l1 != 2) begin bad++; $display("FAIL sweep_lat1 d=%0d a=%0d got=%0d exp=2", d, a, l1); end
                if (l15 != 16) begin bad++; $display("FAIL sweep_lat15 d=%0d a=%0d got=%0d exp=16", d, a, l15); end
                if (r1 !== e) begin bad++; $display("FAIL sweep_res1 d=%0d a=%0d got=%h exp=%h", d, a, r1, e); end
                if (r15 !== e) begin bad++; $display("FAIL sweep_res15 d=%0d a=%0d got=%h exp=%h", d, a, r15, e); end
            end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_left_and_zero;
        test_round_robin;
        test_back_pressure;
        test_reset_mid;
        test_settle_sweep;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rotator_share_ctrl.md
# rotator_share_ctrl

Sequencing and arbitration controller for the team's 16-bit barrel rotator (combinational mux-tree rotate-right, 4-bit select). It shares one rotator instance between two requesters using round-robin arbitration. It drives the rotator's data and select inputs from registered operands, waits a programmable settle time for the multi-level mux delay, then captures the rotator output. The captured result is presented on a shared, back-pressurable result port.

## Interface
- SETTLE_CYC, default 2: cycles between operand launch and result capture; legal range 1..15.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req0 / req1  in  1  request from requester 0 / 1; held with stable operands until the matching grant.
- dir0 / dir1  in  1  rotate direction: 0 = right, 1 = left.
- amt0 / amt1  in  4  rotate amount, 0..15.
- data0 / data1  in  16  operand.
- gnt0 / gnt1  out  1  one-cycle accept; operands are sampled at the clock edge ending this cycle.
- res  out  16  rotated result.
- res_vld  out  1  result valid.
- res_id  out  1  index of the requester that owns res.
- res_rdy  in  1  result consumer ready.
- busy  out  1  high whenever state is not IDLE.

## Operation
- Rotator is instantiated internally.
  - Data input = registered operand opnd_q.
  - Select = registered effective amount sel_q.
  - Rotator function: out[i] = in[(i+k) mod 16] (rotate right by k).
- Effective amount:
  - dir=0: k = amt.
  - dir=1: k = (16 − amt) mod 16, computed in 4 bits; left by 0 gives k=0.
- FSM states: IDLE, SETTLE, HOLD.
- IDLE:
  - If any req is high, choose a winner and assert its gnt combinationally.
  - At the edge: load opnd_q, sel_q and owner_q; set cnt = SETTLE_CYC−1; go to SETTLE; update last_q = winner.
  - If no req, stay in IDLE.
- Arbitration:
  - If only one req is high, that requester wins.
  - If both are high, the winner is the requester ≠ last_q.
  - last_q resets to 1, so requester 0 wins the first tie.
- SETTLE:
  - If cnt ≠ 0, decrement cnt each edge.
  - At the edge where cnt == 0: capture rotator output into res, set res_id = owner_q and res_vld = 1, go to HOLD.
- HOLD:
  - res, res_id and res_vld are held stable.
  - At an edge with res_rdy=1: clear res_vld, go to IDLE.
- Grants are issued only in IDLE. Requests raised in SETTLE or HOLD get no grant, are not lost, and are arbitrated on return to IDLE.
- res_rdy is ignored outside HOLD.
- Operand inputs are don't-care except in the grant cycle.

## Timing
- Reset values: state=IDLE, res=0, res_vld=0, res_id=0, gnt0=gnt1=0, busy=0, last_q=1, cnt=0, opnd_q=0, sel_q=0.
- Reset asserted mid-operation: everything returns to reset values immediately (asynchronously); an in-flight operation is discarded and no result is produced.
- Latency, grant cycle c0 to result:
  - SETTLE occupies c1..c(SETTLE_CYC).
  - res_vld is first high in cycle c(SETTLE_CYC+1).
- Minimum issue interval with res_rdy tied high: SETTLE_CYC+2 cycles (grant, SETTLE_CYC settle cycles, one HOLD cycle).
- gnt is never asserted while busy=1.
- gnt0 and gnt1 are never high together.
- Capture always occurs at least SETTLE_CYC full cycles after opnd_q/sel_q change, which covers the rotator's two-level mux delay at the target clock.

## Test plan
- Reset, then req0 with data0=16'h8001, amt0=1, dir0=0, SETTLE_CYC=2, res_rdy=1 → gnt0 in c0, res=16'hC000, res_id=0, res_vld high in c3 only, back in IDLE at c4.
- req1 with data1=16'h1234, amt1=4, dir1=1 → res=16'h2341, res_id=1. The same data with amt=0, either dir → res=16'h1234.
- req0 and req1 held high continuously, res_rdy=1 → grants alternate 0,1,0,1 starting with gnt0; each res_id matches the granted requester.
- Back-pressure: res_rdy=0 for 5 cycles after res_vld rises → res, res_id and res_vld stable throughout, no grant issued. res_rdy=1 → res_vld drops next cycle, pending request granted the following cycle.
- rst_n pulsed low during SETTLE → all outputs at reset values immediately, no res_vld afterwards; a new req0 after release completes normally with gnt0 first.
- SETTLE_CYC=1 and SETTLE_CYC=15 → res_vld first high 2 and 16 cycles after the grant cycle respectively; results are correct for all 16 amounts in both directions on data=16'hA5C3.
